// File: rtl/sequence_game_engine.sv
// rtl/sequence_game_engine.sv - programmable multi-game input-sequence challenge FSM
// Runs N_GAMES table-driven step sequences with lives, per-step timeout and quiz pause/resume.
module sequence_game_engine #(
    parameter int IN_W          = 9,
    parameter int N_GAMES       = 3,
    parameter int MAX_STEPS     = 8,
    parameter int LIVES_INIT    = 3,
    parameter int TIMEOUT_TICKS = 0
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           start,
    input  logic                           ack,
    input  logic [IN_W-1:0]                in_vec,
    input  logic                           tick,
    input  logic                           time_up,
    input  logic                           intr,
    input  logic                           intr_done,
    input  logic                           intr_pass,
    input  logic                           cfg_we,
    input  logic [$clog2(N_GAMES)-1:0]     cfg_game,
    input  logic [$clog2(MAX_STEPS)-1:0]   cfg_step,
    input  logic [IN_W-1:0]                cfg_pat,
    input  logic                           cfg_len_we,
    input  logic [$clog2(MAX_STEPS):0]     cfg_len,
    output logic [2:0]                     state_o,
    output logic [$clog2(N_GAMES)-1:0]     game_idx,
    output logic [$clog2(MAX_STEPS)-1:0]   step_idx,
    output logic [$clog2(LIVES_INIT+1)-1:0] lives,
    output logic                           miss
);

    localparam int GW = $clog2(N_GAMES);
    localparam int SW = $clog2(MAX_STEPS);
    localparam int LW = SW + 1;
    localparam int VW = $clog2(LIVES_INIT + 1);
    localparam int TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_QUIZ    = 3'd2,
        S_RECOVER = 3'd3,
        S_CLEAR   = 3'd4,
        S_WIN     = 3'd5,
        S_LOSE    = 3'd6
    } state_t;

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    logic [GW-1:0]     game_q, game_d;
    logic [SW-1:0]     step_q, step_d;
    logic [VW-1:0]     lives_q, lives_d;
    logic              miss_q, miss_d;
    logic [IN_W-1:0]   prev_q, prev_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [IN_W-1:0]   pat_q [N_GAMES][MAX_STEPS];
    logic [IN_W-1:0]   pat_d [N_GAMES][MAX_STEPS];
    logic [LW-1:0]     len_q [N_GAMES];
    logic [LW-1:0]     len_d [N_GAMES];

    logic              do_miss;
    logic              match;
    logic              last_step;
    logic              timeout;
    logic [TW-1:0]     timer_inc;
    logic [IN_W-1:0]   cur_pat;

    assign cur_pat   = pat_q[game_q][step_q];
    assign match     = (in_vec == cur_pat);
    assign last_step = ({1'b0, step_q} == (len_q[game_q] - LW'(1)));
    assign timer_inc = (tick && (timer_q != TMAX)) ? timer_q + TW'(1) : timer_q;
    assign timeout   = (TIMEOUT_TICKS != 0) && (timer_inc == TMAX);

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        game_d  = game_q;
        step_d  = step_q;
        lives_d = lives_q;
        miss_d  = 1'b0;
        prev_d  = prev_q;
        timer_d = timer_q;
        pat_d   = pat_q;
        len_d   = len_q;
        do_miss = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_we && (int'(cfg_game) < N_GAMES) && (int'(cfg_step) < MAX_STEPS)) begin
                    pat_d[cfg_game][cfg_step] = cfg_pat;
                end
                if (cfg_len_we && (int'(cfg_game) < N_GAMES)) begin
                    if ((cfg_len == '0) || (int'(cfg_len) > MAX_STEPS)) begin
                        len_d[cfg_game] = LW'(MAX_STEPS);
                    end else begin
                        len_d[cfg_game] = cfg_len;
                    end
                end
                if (start) begin
                    state_d = S_PLAY;
                    lives_d = VW'(LIVES_INIT);
                    game_d  = '0;
                    step_d  = '0;
                    prev_d  = '0;
                    timer_d = '0;
                end
            end
            S_PLAY: begin
                if (time_up) begin
                    state_d = S_LOSE;
                end else if (intr) begin
                    state_d = S_QUIZ;
                    ret_d   = S_PLAY;
                end else if (match) begin
                    prev_d  = cur_pat;
                    timer_d = '0;
                    if (last_step) begin
                        state_d = S_CLEAR;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end else begin
                    // A timeout overrides a neutral (held) input; only a match beats it.
                    timer_d = timer_inc;
                    if (timeout || (in_vec != prev_q)) begin
                        do_miss = 1'b1;
                    end
                end
            end
            S_RECOVER: begin
                if (time_up) begin
                    state_d = S_LOSE;
                end else if (intr) begin
                    state_d = S_QUIZ;
                    ret_d   = S_RECOVER;
                end else if (in_vec == '0) begin
                    state_d = S_PLAY;
                end
            end
            S_QUIZ: begin
                if (intr_done) begin
                    if (intr_pass) begin
                        state_d = ret_q;
                        timer_d = '0;
                    end else begin
                        do_miss = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (time_up) begin
                    state_d = S_LOSE;
                end else if (in_vec == '0) begin
                    if (int'(game_q) == N_GAMES - 1) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_PLAY;
                        game_d  = game_q + GW'(1);
                        step_d  = '0;
                        prev_d  = '0;
                        timer_d = '0;
                    end
                end
            end
            S_WIN, S_LOSE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_miss) begin
            miss_d = 1'b1;
            if (lives_q == VW'(1)) begin
                state_d = S_LOSE;
                lives_d = '0;
            end else begin
                state_d = S_RECOVER;
                lives_d = lives_q - VW'(1);
                step_d  = '0;
                prev_d  = '0;
                timer_d = '0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            ret_q   <= S_PLAY;
            game_q  <= '0;
            step_q  <= '0;
            lives_q <= VW'(LIVES_INIT);
            miss_q  <= 1'b0;
            prev_q  <= '0;
            timer_q <= '0;
            for (int g = 0; g < N_GAMES; g++) begin
                len_q[g] <= LW'(1);
                for (int s = 0; s < MAX_STEPS; s++) begin
                    pat_q[g][s] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            game_q  <= game_d;
            step_q  <= step_d;
            lives_q <= lives_d;
            miss_q  <= miss_d;
            prev_q  <= prev_d;
            timer_q <= timer_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
        end
    end

    assign state_o  = state_q;
    assign game_idx = game_q;
    assign step_idx = step_q;
    assign lives    = lives_q;
    assign miss     = miss_q;

endmodule
